// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg: opcodes, instruction field layout and multiplier FSM
// encoding shared by the mini_alu_core slice.
package mini_alu_pkg;

    localparam int INSTR_W = 28;

    localparam int OP_HI   = 27;
    localparam int OP_LO   = 24;
    localparam int DST_HI  = 23;
    localparam int DST_LO  = 16;
    localparam int SRC1_HI = 15;
    localparam int SRC1_LO = 8;
    localparam int SRC0_HI = 7;
    localparam int SRC0_LO = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LED  = 4'd1;
    localparam logic [3:0] OP_STO  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_SMUL = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;

    typedef enum logic [1:0] {
        MUL_IDLE  = 2'd0,
        MUL_RUN   = 2'd1,
        MUL_WR_LO = 2'd2,
        MUL_WR_HI = 2'd3
    } mul_state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] dst;
        logic [7:0] src1;
        logic [7:0] src0;
    } instr_t;

    localparam instr_t NOP_INSTR = '0;

    function automatic instr_t decodeInstr(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.op   = w[OP_HI:OP_LO];
        d.dst  = w[DST_HI:DST_LO];
        d.src1 = w[SRC1_HI:SRC1_LO];
        d.src0 = w[SRC0_HI:SRC0_LO];
        return d;
    endfunction

endpackage

// File: rtl/mini_alu_core_if.sv
// mini_alu_core_if: instruction-fetch bus between the core and its
// external combinational ROM.
interface mini_alu_core_if #(
    parameter int IP_WIDTH = 16
);
    logic [IP_WIDTH-1:0]              oIAddress;
    logic [mini_alu_pkg::INSTR_W-1:0] iInstruction;

    modport master (output oIAddress, input iInstruction);
    modport slave  (input oIAddress, output iInstruction);
endinterface

// File: rtl/mini_alu_mul_seq.sv
// mini_alu_mul_seq: iterative shift-add multiplier, one multiplier bit
// per cycle, sign handled by magnitude multiply plus final negate.
module mini_alu_mul_seq
    import mini_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  isSigned,
    input  logic [DATA_WIDTH-1:0] opA,
    input  logic [DATA_WIDTH-1:0] opB,
    output logic                  busy,
    output logic                  loValid,
    output logic                  hiValid,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    mul_state_t state, stateNext;
    logic [PW-1:0] acc, mcand, prod;
    logic [DATA_WIDTH-1:0] mplier, magA, magB;
    logic [CW-1:0] count;
    logic neg, lastBit;

    assign magA = (isSigned && opA[DATA_WIDTH-1]) ? -opA : opA;
    assign magB = (isSigned && opB[DATA_WIDTH-1]) ? -opB : opB;
    assign lastBit = count == CW'(DATA_WIDTH - 1);
    assign prod = (state == MUL_WR_LO && neg) ? -acc : acc;
    assign lo = prod[DATA_WIDTH-1:0];
    assign hi = acc[PW-1:DATA_WIDTH];
    assign busy = state != MUL_IDLE;
    assign loValid = state == MUL_WR_LO;
    assign hiValid = state == MUL_WR_HI;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= MUL_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            MUL_IDLE:  if (start) stateNext = MUL_RUN;
            MUL_RUN:   if (lastBit) stateNext = MUL_WR_LO;
            MUL_WR_LO: stateNext = MUL_WR_HI;
            MUL_WR_HI: stateNext = MUL_IDLE;
            default:   stateNext = MUL_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= PW'(magA);
                        mplier <= magB;
                        count  <= '0;
                        neg    <= isSigned &&
                                  (opA[DATA_WIDTH-1] ^ opB[DATA_WIDTH-1]);
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                // Product is committed signed here so WR_HI reads it back.
                MUL_WR_LO: acc <= prod;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mini_alu_core.sv
// mini_alu_core: two-stage fetch/execute core with a 256-entry register
// file, squashing branches and a stalling iterative multiplier.
module mini_alu_core
    import mini_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IP_WIDTH   = 16,
    parameter int LED_WIDTH  = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    mini_alu_core_if.master      bus,
    output logic [LED_WIDTH-1:0] oLed,
    output logic                 oBusy,
    output logic                 oRetire
);
    logic [IP_WIDTH-1:0] ip, target;
    instr_t ex;
    logic exValid;

    logic [DATA_WIDTH-1:0] regs [256];
    logic [DATA_WIDTH-1:0] opA, opB, imm, aluRes, mulLo, mulHi, wrData;
    logic [7:0] wrAddr;
    logic aluWr, wrEn, taken, stall;
    logic exIsMul, mulStart, mulLoValid, mulHiValid;

    assign opA = regs[ex.src1];
    assign opB = regs[ex.src0];
    assign imm = DATA_WIDTH'({ex.src1, ex.src0});
    assign target = IP_WIDTH'(ex.dst);
    assign exIsMul = exValid && (ex.op == OP_MUL || ex.op == OP_SMUL);
    assign mulStart = exIsMul && !oBusy;
    // EX is released on the WR_HI cycle so the mul occupies W+3 cycles.
    assign stall = exIsMul && !mulHiValid;
    assign oRetire = exValid && (!exIsMul || mulHiValid);
    assign bus.oIAddress = ip;

    always_comb begin
        taken = 1'b0;
        if (exValid) begin
            case (ex.op)
                OP_BLE:  taken = opA <= opB;
                OP_BEQ:  taken = opA == opB;
                OP_JMP:  taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        aluWr  = 1'b0;
        aluRes = '0;
        case (ex.op)
            OP_STO: begin
                aluWr  = 1'b1;
                aluRes = imm;
            end
            OP_ADD: begin
                aluWr  = 1'b1;
                aluRes = opA + opB;
            end
            OP_SUB: begin
                aluWr  = 1'b1;
                aluRes = opA - opB;
            end
            OP_SHL: begin
                aluWr  = 1'b1;
                aluRes = (opB >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : opA << opB;
            end
            OP_SHR: begin
                aluWr  = 1'b1;
                aluRes = (opB >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : opA >> opB;
            end
            OP_NOP:  aluWr = 1'b0;
            default: aluWr = 1'b0;
        endcase
    end

    always_comb begin
        wrEn   = 1'b0;
        wrAddr = ex.dst;
        wrData = aluRes;
        if (mulLoValid) begin
            wrEn   = 1'b1;
            wrData = mulLo;
        end else if (mulHiValid) begin
            wrEn   = 1'b1;
            wrAddr = ex.dst + 8'd1;
            wrData = mulHi;
        end else if (exValid && aluWr) begin
            wrEn = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ip      <= '0;
            ex      <= NOP_INSTR;
            exValid <= 1'b0;
        end else if (taken) begin
            ip      <= target;
            ex      <= NOP_INSTR;
            exValid <= 1'b0;
        end else if (!stall) begin
            ip      <= ip + IP_WIDTH'(1);
            ex      <= decodeInstr(bus.iInstruction);
            exValid <= 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) oLed <= '0;
        else if (exValid && ex.op == OP_LED) oLed <= opA[LED_WIDTH-1:0];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 256; i++) regs[i] <= '0;
        end else if (wrEn) begin
            regs[wrAddr] <= wrData;
        end
    end

    mini_alu_mul_seq #(
        .DATA_WIDTH(DATA_WIDTH)
    ) uMul (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (mulStart),
        .isSigned(ex.op == OP_SMUL),
        .opA     (opA),
        .opB     (opB),
        .busy    (oBusy),
        .loValid (mulLoValid),
        .hiValid (mulHiValid),
        .lo      (mulLo),
        .hi      (mulHi)
    );

endmodule
